// File: rtl/cpu_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch gets a zero-latency next-PC prediction; the resolve port checks it, redirects/flushes and trains.
module cpu_branch_predictor #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned CNT_W   = 16,
  parameter bit          PRED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_f_valid,
  input  logic [WIDTH-1:0] i_f_pc,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_pc,
  input  logic             i_r_valid,
  input  logic [WIDTH-1:0] i_r_pc,
  input  logic             i_r_taken,
  input  logic [WIDTH-1:0] i_r_target,
  input  logic [WIDTH-1:0] i_r_pred_pc,
  output logic             o_redirect,
  output logic [WIDTH-1:0] o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned TAG_W = WIDTH - IDX_W - 1;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [WIDTH-1:0] r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [WIDTH-1:0] w_f_seq;
  logic [IDX_W-1:0] w_r_idx;
  logic [TAG_W-1:0] w_r_tag;
  logic             w_r_hit;
  logic [WIDTH-1:0] w_actual_pc;
  logic             w_mispred;
  logic [1:0]       w_ctr_nxt;

  // Fetch lookup; i_f_valid only qualifies the result downstream
  always_comb begin
    w_f_idx      = i_f_pc[IDX_W:1];
    w_f_tag      = i_f_pc[WIDTH-1:IDX_W+1];
    w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_f_seq      = i_f_pc + WIDTH'(2);
    o_pred_taken = PRED_EN && w_f_hit && r_ctr[w_f_idx][1];
    o_pred_pc    = o_pred_taken ? r_target[w_f_idx] : w_f_seq;
  end

  // Resolve check and next counter value for the resolved entry
  always_comb begin
    w_r_idx       = i_r_pc[IDX_W:1];
    w_r_tag       = i_r_pc[WIDTH-1:IDX_W+1];
    w_r_hit       = r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    w_actual_pc   = i_r_taken ? i_r_target : (i_r_pc + WIDTH'(2));
    w_mispred     = i_r_valid && (w_actual_pc != i_r_pred_pc);
    o_redirect    = w_mispred;
    o_flush       = w_mispred;
    o_redirect_pc = w_actual_pc;
    w_ctr_nxt     = r_ctr[w_r_idx];
    if (i_r_taken && (r_ctr[w_r_idx] != 2'b11)) begin
      w_ctr_nxt = r_ctr[w_r_idx] + 2'd1;
    end else if (!i_r_taken && (r_ctr[w_r_idx] != 2'b00)) begin
      w_ctr_nxt = r_ctr[w_r_idx] - 2'd1;
    end
  end

  // Table training and mispredict statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= '0;
      r_tag         <= '{default: '0};
      r_target      <= '{default: '0};
      r_ctr         <= '{default: 2'b01};
      r_mispred_cnt <= '0;
    end else begin
      if (i_r_valid) begin
        if (w_r_hit) begin
          r_ctr[w_r_idx] <= w_ctr_nxt;
          if (i_r_taken) begin
            r_target[w_r_idx] <= i_r_target;
          end
        end else if (i_r_taken) begin
          r_valid[w_r_idx]  <= 1'b1;
          r_tag[w_r_idx]    <= w_r_tag;
          r_target[w_r_idx] <= i_r_target;
          r_ctr[w_r_idx]    <= 2'b10;
        end
      end
      if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Scoreboard bench for cpu_branch_predictor: a default instance and a CNT_W=2 / PRED_EN=0 instance.
module tb_cpu_branch_predictor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Unit 0: defaults
  logic        f_valid0 = 1'b1, r_valid0 = 1'b0, r_taken0 = 1'b0;
  logic [15:0] f_pc0 = 16'h0040, r_pc0 = 16'h0, r_target0 = 16'h0, r_pred_pc0 = 16'h0;
  logic        pred_taken0, redirect0, flush0;
  logic [15:0] pred_pc0, redirect_pc0, cnt0;

  // Unit 1: 2-bit counter, static not-taken
  logic        f_valid1 = 1'b1, r_valid1 = 1'b0, r_taken1 = 1'b0;
  logic [15:0] f_pc1 = 16'h0040, r_pc1 = 16'h0, r_target1 = 16'h0, r_pred_pc1 = 16'h0;
  logic        pred_taken1, redirect1, flush1;
  logic [15:0] pred_pc1, redirect_pc1;
  logic [1:0]  cnt1;

  cpu_branch_predictor u_dut0 (
    .clk(clk), .reset(reset), .i_f_valid(f_valid0), .i_f_pc(f_pc0),
    .o_pred_taken(pred_taken0), .o_pred_pc(pred_pc0),
    .i_r_valid(r_valid0), .i_r_pc(r_pc0), .i_r_taken(r_taken0),
    .i_r_target(r_target0), .i_r_pred_pc(r_pred_pc0),
    .o_redirect(redirect0), .o_redirect_pc(redirect_pc0), .o_flush(flush0),
    .o_mispred_cnt(cnt0)
  );

  cpu_branch_predictor #(.WIDTH(16), .IDX_W(3), .CNT_W(2), .PRED_EN(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .i_f_valid(f_valid1), .i_f_pc(f_pc1),
    .o_pred_taken(pred_taken1), .o_pred_pc(pred_pc1),
    .i_r_valid(r_valid1), .i_r_pc(r_pc1), .i_r_taken(r_taken1),
    .i_r_target(r_target1), .i_r_pred_pc(r_pred_pc1),
    .o_redirect(redirect1), .o_redirect_pc(redirect_pc1), .o_flush(flush1),
    .o_mispred_cnt(cnt1)
  );

  typedef struct {
    string       name;
    int          unit;
    logic        pt;
    logic [15:0] ppc;
    logic        red;
    logic [15:0] rpc;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: outputs are sampled mid-cycle, after inputs settle and before the training edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic        a_pt, a_red, a_fl;
      logic [15:0] a_ppc, a_rpc, a_cnt;
      e = exp_q.pop_front();
      if (e.unit == 0) begin
        a_pt = pred_taken0; a_ppc = pred_pc0; a_red = redirect0; a_fl = flush0;
        a_rpc = redirect_pc0; a_cnt = cnt0;
      end else begin
        a_pt = pred_taken1; a_ppc = pred_pc1; a_red = redirect1; a_fl = flush1;
        a_rpc = redirect_pc1; a_cnt = {14'h0, cnt1};
      end
      checks++;
      if (a_pt !== e.pt || a_ppc !== e.ppc || a_red !== e.red || a_fl !== e.red ||
          a_rpc !== e.rpc || a_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s unit%0d: got pt=%0b ppc=%h red=%0b flush=%0b rpc=%h cnt=%h, want pt=%0b ppc=%h red/flush=%0b rpc=%h cnt=%h",
                 e.name, e.unit, a_pt, a_ppc, a_red, a_fl, a_rpc, a_cnt,
                 e.pt, e.ppc, e.red, e.rpc, e.cnt);
      end
    end
  end

  task automatic cyc(input int unit, input logic [15:0] fpc, input logic rv,
                     input logic [15:0] rpc, input logic rt, input logic [15:0] rtg,
                     input logic [15:0] rpp, input string name, input logic xpt,
                     input logic [15:0] xppc, input logic xred, input logic [15:0] xrpc,
                     input logic [15:0] xcnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (unit == 0) begin
      f_pc0 = fpc; r_valid0 = rv; r_pc0 = rpc; r_taken0 = rt; r_target0 = rtg; r_pred_pc0 = rpp;
    end else begin
      f_pc1 = fpc; r_valid1 = rv; r_pc1 = rpc; r_taken1 = rt; r_target1 = rtg; r_pred_pc1 = rpp;
    end
    e.name = name; e.unit = unit; e.pt = xpt; e.ppc = xppc;
    e.red = xred; e.rpc = xrpc; e.cnt = xcnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unit, input logic [15:0] fpc, input string name,
                      input logic xpt, input logic [15:0] xppc, input logic [15:0] xcnt);
    cyc(unit, fpc, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, name, xpt, xppc, 1'b0, 16'h0002, xcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    e.name = "reset"; e.unit = 0; e.pt = 1'b0; e.ppc = 16'h0042;
    e.red = 1'b0; e.rpc = 16'h0002; e.cnt = 16'h0;
    exp_q.push_back(e);
    @(negedge clk);
    #1 reset = 1'b0;

    // Allocate, then weaken to strong not-taken; same-cycle lookup sees old contents
    cyc(0, 16'h0040, 1, 16'h0040, 1, 16'h0100, 16'h0042, "alloc", 0, 16'h0042, 1, 16'h0100, 0);
    idle(0, 16'h0040, "alloc_vis", 1, 16'h0100, 1);
    cyc(0, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0100, "same_cyc", 1, 16'h0100, 1, 16'h0042, 1);
    cyc(0, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0042, "nt2", 0, 16'h0042, 0, 16'h0042, 2);
    cyc(0, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0042, "nt3", 0, 16'h0042, 0, 16'h0042, 2);
    cyc(0, 16'h0040, 1, 16'h0040, 1, 16'h0100, 16'h0042, "from00", 0, 16'h0042, 1, 16'h0100, 2);
    idle(0, 16'h0040, "ctr01", 0, 16'h0042, 3);
    // Drive up to strong taken and check the upper clamp
    cyc(0, 16'h0040, 1, 16'h0040, 1, 16'h0180, 16'h0042, "tk_a", 0, 16'h0042, 1, 16'h0180, 3);
    cyc(0, 16'h0040, 1, 16'h0040, 1, 16'h0180, 16'h0180, "tk_b", 1, 16'h0180, 0, 16'h0180, 4);
    cyc(0, 16'h0040, 1, 16'h0040, 1, 16'h0180, 16'h0180, "tk_c", 1, 16'h0180, 0, 16'h0180, 4);
    cyc(0, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0180, "from11", 1, 16'h0180, 1, 16'h0042, 4);
    idle(0, 16'h0040, "ctr10", 1, 16'h0180, 5);
    // Alias eviction: 0x0050 shares index 0 with 0x0040
    cyc(0, 16'h0050, 1, 16'h0050, 1, 16'h0200, 16'h0052, "alias", 0, 16'h0052, 1, 16'h0200, 5);
    idle(0, 16'h0040, "evicted", 0, 16'h0042, 6);
    idle(0, 16'h0050, "alias_hit", 1, 16'h0200, 6);
    // Not-taken miss leaves the table alone
    cyc(0, 16'h0044, 1, 16'h0044, 0, 16'h0300, 16'h0046, "nt_miss", 0, 16'h0046, 0, 16'h0046, 6);
    idle(0, 16'h0044, "nt_nochg", 0, 16'h0046, 6);
    // PC wrap on both ports
    cyc(0, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, "wrap", 0, 16'h0000, 0, 16'h0000, 6);
    cyc(0, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 16'h1234, "wrap_mis", 0, 16'h0000, 1, 16'h0000, 6);
    idle(0, 16'h0050, "pre_rst", 1, 16'h0200, 7);
    // Mid-operation reset clears table and counter at once
    idle(0, 16'h0050, "mid_rst", 0, 16'h0052, 0);
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;

    // Unit 1: saturating 2-bit counter, static not-taken despite training
    for (int k = 0; k < 5; k++) begin
      cyc(1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 16'h0042, "sat_mis", 0, 16'h0042, 1, 16'h0100,
          (k > 3) ? 16'd3 : 16'(k));
    end
    idle(1, 16'h0040, "sat_hold", 0, 16'h0042, 3);
    cyc(1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 16'h0100, "correct", 0, 16'h0042, 0, 16'h0100, 3);
    idle(1, 16'h0040, "static_nt", 0, 16'h0042, 3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
